// File: rtl/pmux_sched.sv
// Four-input packet multiplexer: arbitrates requesters, holds the winner's payload until accepted.
// Define PMUX_SCHED_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (0 highest) otherwise.
module pmux_sched #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        req_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [DATA_W-1:0] data_2_i,
  input  logic [DATA_W-1:0] data_3_i,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] q_o,
  output logic              q_valid_o,
  output logic [3:0]        gnt_o,
  output logic [1:0]        gnt_idx_o,
  output logic              busy_o,
  output logic [15:0]       xfer_cnt_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_capture;
  logic              w_accept;
  logic [1:0]        w_win_idx;
  logic [DATA_W-1:0] w_win_data;
  logic [DATA_W-1:0] r_q;
  logic [1:0]        r_gnt_idx;
  logic [15:0]       r_xfer_cnt;

`ifdef PMUX_SCHED_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic [1:0] w_cand;

  // Scan downward so the requester closest above the pointer is the last one written.
  always_comb begin
    w_win_idx = r_ptr;
    w_cand    = '0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req_i[w_cand]) w_win_idx = w_cand;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= r_gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    w_win_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req_i[k]) w_win_idx = 2'(k);
    end
  end
`endif

  always_comb begin
    case (w_win_idx)
      2'd0:    w_win_data = data_0_i;
      2'd1:    w_win_data = data_1_i;
      2'd2:    w_win_data = data_2_i;
      default: w_win_data = data_3_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Reset masks the accept so a discarded transfer never produces a grant pulse.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    gnt_o        = '0;
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i && !rst_i) begin
          w_accept     = 1'b1;
          gnt_o        = 4'b0001 << r_gnt_idx;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q        <= '0;
      r_gnt_idx  <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_q       <= w_win_data;
        r_gnt_idx <= w_win_idx;
      end
      if (w_accept) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign q_o        = r_q;
  assign q_valid_o  = (r_state == HOLD);
  assign busy_o     = (r_state == HOLD);
  assign gnt_idx_o  = r_gnt_idx;
  assign xfer_cnt_o = r_xfer_cnt;

endmodule

// File: tb/tb_pmux_sched.sv
// Directed self-checking bench for pmux_sched; inputs driven and outputs sampled on the falling edge.
module tb_pmux_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [15:0] data_0_i, data_1_i, data_2_i, data_3_i;
  logic        out_ready_i;
  logic [15:0] q_o;
  logic        q_valid_o;
  logic [3:0]  gnt_o;
  logic [1:0]  gnt_idx_o;
  logic        busy_o;
  logic [15:0] xfer_cnt_o;

  int testsRun = 0;
  int testsFailed = 0;

  pmux_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
    .data_0_i(data_0_i), .data_1_i(data_1_i), .data_2_i(data_2_i), .data_3_i(data_3_i),
    .out_ready_i(out_ready_i), .q_o(q_o), .q_valid_o(q_valid_o), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = '0; out_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic do_transfer(input int idx, input logic [15:0] d);
    req_i = 4'b0001 << idx;
    case (idx)
      0: data_0_i = d;
      1: data_1_i = d;
      2: data_2_i = d;
      default: data_3_i = d;
    endcase
    out_ready_i = 1'b1;
    tick();
    req_i = '0;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 4'hF; out_ready_i = 1'b1;
    tick(); tick();
    #1;
    testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_gnt got %h want 0", gnt_o); end
    testsRun++; if (q_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", q_valid_o); end
    testsRun++; if (q_o !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_q got %h want 0", q_o); end
    testsRun++; if (gnt_idx_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_idx got %0d want 0", gnt_idx_o); end
    testsRun++; if (xfer_cnt_o !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_cnt got %h want 0", xfer_cnt_o); end
    testsRun++; if (busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    tick();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0100; data_2_i = 16'h1234; out_ready_i = 1'b1;
    #1;
    testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL single_idle_gnt got %h want 0", gnt_o); end
    tick();
    testsRun++; if (q_o !== 16'h1234) begin testsFailed++; $display("[TB] FAIL single_q got %h want 1234", q_o); end
    testsRun++; if (q_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_valid got %b want 1", q_valid_o); end
    testsRun++; if (gnt_idx_o !== 2'd2) begin testsFailed++; $display("[TB] FAIL single_idx got %0d want 2", gnt_idx_o); end
    testsRun++; if (busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy got %b want 1", busy_o); end
    testsRun++; if (gnt_o !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_gnt got %b want 0100", gnt_o); end
    req_i = '0;
    tick();
    testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL single_gnt_after got %b want 0000", gnt_o); end
    testsRun++; if (q_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_valid_after got %b want 0", q_valid_o); end
    testsRun++; if (xfer_cnt_o !== 16'd1) begin testsFailed++; $display("[TB] FAIL single_cnt got %0d want 1", xfer_cnt_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_contention();
    int expOrder[5];
    int nGrants;
    logic [15:0] expQ;
    logic [3:0] expGnt;
    do_reset();
    expOrder = '{0, 1, 2, 3, 0};
`ifdef PMUX_SCHED_ROUND_ROBIN_EN
    nGrants = 5;
`else
    nGrants = 4;
`endif
    data_0_i = 16'hA000; data_1_i = 16'hA001; data_2_i = 16'hA002; data_3_i = 16'hA003;
    req_i = 4'hF; out_ready_i = 1'b1;
    for (int g = 0; g < nGrants; g++) begin
      int waitCnt;
      waitCnt = 0;
      tick();
      while (!q_valid_o && waitCnt < 4) begin tick(); waitCnt++; end
      #1;
      expQ = 16'hA000 + 16'(expOrder[g]);
      expGnt = 4'b0001 << expOrder[g];
      testsRun++; if (q_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL contention_timeout grant %0d valid %b want 1", g, q_valid_o); end
      testsRun++; if (gnt_idx_o !== 2'(expOrder[g])) begin testsFailed++; $display("[TB] FAIL contention_order grant %0d got %0d want %0d", g, gnt_idx_o, expOrder[g]); end
      testsRun++; if (gnt_o !== expGnt) begin testsFailed++; $display("[TB] FAIL contention_gnt grant %0d got %b want %b", g, gnt_o, expGnt); end
      testsRun++; if (q_o !== expQ) begin testsFailed++; $display("[TB] FAIL contention_q grant %0d got %h want %h", g, q_o, expQ); end
`ifndef PMUX_SCHED_ROUND_ROBIN_EN
      req_i[expOrder[g]] = 1'b0;
`endif
    end
    req_i = '0;
    tick(); tick();
    testsRun++; if (xfer_cnt_o !== 16'(nGrants)) begin testsFailed++; $display("[TB] FAIL contention_cnt got %0d want %0d", xfer_cnt_o, nGrants); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_i = 4'b0001; data_0_i = 16'hBEEF; out_ready_i = 1'b0;
    tick();
    testsRun++; if (q_o !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL bp_capture got %h want beef", q_o); end
    for (int i = 0; i < 5; i++) begin
      data_0_i = 16'h0100 + 16'(i);
      req_i = (i % 2 == 0) ? 4'b1110 : 4'b0001;
      #1;
      testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL bp_gnt cycle %0d got %b want 0000", i, gnt_o); end
      tick();
      testsRun++; if (q_o !== 16'hBEEF || gnt_idx_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL bp_hold cycle %0d got %h/%0d want beef/0", i, q_o, gnt_idx_o); end
    end
    req_i = 4'b0001; out_ready_i = 1'b1;
    #1;
    testsRun++; if (gnt_o !== 4'b0001) begin testsFailed++; $display("[TB] FAIL bp_release_gnt got %b want 0001", gnt_o); end
    req_i = '0;
    tick();
    testsRun++; if (gnt_o !== 4'h0 || q_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_single_pulse gnt %b valid %b want 0000/0", gnt_o, q_valid_o); end
    testsRun++; if (xfer_cnt_o !== 16'd1) begin testsFailed++; $display("[TB] FAIL bp_cnt got %0d want 1", xfer_cnt_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    do_transfer(1, 16'h0F0F);
    req_i = 4'b1000; data_3_i = 16'h5A5A;
    tick();
    testsRun++; if (q_valid_o !== 1'b1 || xfer_cnt_o !== 16'd1) begin testsFailed++; $display("[TB] FAIL rsthold_pre valid %b cnt %0d want 1/1", q_valid_o, xfer_cnt_o); end
    rst_i = 1'b1; out_ready_i = 1'b1; req_i = '0;
    #1;
    testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL rsthold_gnt got %b want 0000", gnt_o); end
    tick();
    rst_i = 1'b0;
    #1;
    testsRun++; if (q_valid_o !== 1'b0 || q_o !== 16'h0) begin testsFailed++; $display("[TB] FAIL rsthold_clear valid %b q %h want 0/0", q_valid_o, q_o); end
    testsRun++; if (xfer_cnt_o !== 16'h0 || gnt_idx_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL rsthold_cnt cnt %0d idx %0d want 0/0", xfer_cnt_o, gnt_idx_o); end
    testsRun++; if (gnt_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL rsthold_nognt got %b want 0000", gnt_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic expValid;
    do_reset();
    req_i = 4'b0010; data_1_i = 16'h1111; out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expValid = (i % 2 == 0);
      testsRun++; if (q_valid_o !== expValid) begin testsFailed++; $display("[TB] FAIL b2b_valid cycle %0d got %b want %b", i, q_valid_o, expValid); end
      testsRun++; if (xfer_cnt_o !== 16'((i + 1) / 2)) begin testsFailed++; $display("[TB] FAIL b2b_cnt cycle %0d got %0d want %0d", i, xfer_cnt_o, (i + 1) / 2); end
    end
    req_i = '0; out_ready_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_xfer_cnt = 16'hFFFF;
    tick();
    release dut.r_xfer_cnt;
    tick();
    testsRun++; if (xfer_cnt_o !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL wrap_preload got %h want ffff", xfer_cnt_o); end
    do_transfer(3, 16'h7777);
    testsRun++; if (xfer_cnt_o !== 16'h0000) begin testsFailed++; $display("[TB] FAIL wrap_cnt got %h want 0000", xfer_cnt_o); end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = '0; out_ready_i = 1'b0;
    data_0_i = '0; data_1_i = '0; data_2_i = '0; data_3_i = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_in_hold();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
